// File: rtl/seg_decoder.sv
// seg_decoder: samples a multiplexed 7-segment display and rebuilds the 4-digit hex value it shows
module seg_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  segments,
    input  logic [3:0]  digit,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        valid,
    output logic        frame_done,
    output logic        decode_err
);
    typedef enum logic {SETTLING, HELD} state_t;
    state_t state_q, state_d;
    logic [11:0] s1_q, s2_q, s3_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] nib_q, nib_d, value_q, value_d;
    logic [3:0]  dps_q, dps_d, bad_q, bad_d, seen_q, seen_d, dp_q, dp_d;
    logic        valid_q, valid_d, done_q, done_d, err_q, err_d;
    logic        changed, settle_hit, one_hot, capture, publish, expire;
    logic [3:0]  sel;
    logic [4:0]  dec;

    // returns {bad, nibble}; an unknown pattern yields nibble 0 with bad set
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign changed    = s2_q != s3_q;
    assign settle_hit = !changed && cnt_q == 8'(SETTLE - 1);
    assign sel        = ~s2_q[11:8];
    assign one_hot    = sel != 4'h0 && (sel & (sel - 4'h1)) == 4'h0;
    assign capture    = state_q == SETTLING && settle_hit && one_hot;
    assign publish    = seen_q == 4'hF;
    assign expire     = !capture && tcnt_q == 16'(TIMEOUT - 1);
    assign dec        = decode(~s2_q[6:0]);

    // two-flop synchroniser plus a third stage used only to detect input changes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '1;
            s2_q <= '1;
            s3_q <= '1;
        end else begin
            s1_q <= {digit, segments};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // capture FSM: held after the input has been stable long enough, re-arm on any change
    always_comb begin
        state_d = changed ? SETTLING : settle_hit ? HELD : state_q;
    end

    // stability/timeout counters, slot capture and atomic frame publish
    always_comb begin
        cnt_d   = changed ? 8'h0 : cnt_q == 8'(SETTLE) ? cnt_q : cnt_q + 8'h1;
        tcnt_d  = (capture || expire) ? 16'h0 : tcnt_q + 16'h1;
        nib_d   = nib_q;
        dps_d   = dps_q;
        bad_d   = bad_q;
        seen_d  = seen_q;
        value_d = value_q;
        dp_d    = dp_q;
        err_d   = err_q;
        valid_d = valid_q;
        done_d  = publish;
        if (publish) begin
            value_d = nib_q;
            dp_d    = dps_q;
            err_d   = |bad_q;
            valid_d = 1'b1;
            seen_d  = 4'h0;
            bad_d   = 4'h0;
        end else if (expire) begin
            valid_d = 1'b0;
            seen_d  = 4'h0;
            bad_d   = 4'h0;
        end
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    nib_d[4*i +: 4] = dec[3:0];
                    dps_d[i]        = ~s2_q[7];
                    bad_d[i]        = dec[4];
                    seen_d[i]       = 1'b1;
                end
            end
        end
    end

    // state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SETTLING;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            nib_q   <= '0;
            dps_q   <= '0;
            bad_q   <= '0;
            seen_q  <= '0;
            value_q <= '0;
            dp_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            nib_q   <= nib_d;
            dps_q   <= dps_d;
            bad_q   <= bad_d;
            seen_q  <= seen_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign value      = value_q;
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign frame_done = done_q;
    assign decode_err = err_q;
endmodule

// File: tb/tb_seg_decoder.sv
// tb_seg_decoder: table, directed and random checks of seg_decoder against a sample-history model
module tb_seg_decoder;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  segments;
    logic [3:0]  digit;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid, frame_done, decode_err;

    seg_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .segments(segments), .digit(digit),
        .value(value), .dp(dp), .valid(valid), .frame_done(frame_done), .decode_err(decode_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int frames = 0;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model: remembers the last three pin samples and how long the sampled pair has been steady
    logic [11:0] hq [3];
    int          run;
    int          since;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dpl, m_bad, m_seen, m_dp;
    logic [15:0] m_value;
    logic        m_valid, m_done, m_err;

    typedef struct {
        logic [3:0][7:0] seg;
        bit              junk;
        logic [15:0]     exp_value;
        logic [3:0]      exp_dp;
        logic            exp_err;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [3:0] sel_of(input int i);
        logic [3:0] t;
        t = 4'b0001 << i;
        return ~t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hq[i] = 12'hFFF;
        run = 1;
        since = 0;
        m_seen = 0;
        m_bad = 0;
        m_dpl = 0;
        m_value = 0;
        m_dp = 0;
        m_valid = 0;
        m_done = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input logic [11:0] pin);
        logic [11:0] d;
        int          slot;
        logic [3:0]  nb;
        logic        bd, cap;
        d = hq[1];
        run = (hq[1] == hq[0]) ? run + 1 : 1;
        slot = -1;
        for (int i = 0; i < 4; i++) if (d[11:8] == sel_of(i)) slot = i;
        cap = run == SETTLE + 1 && slot >= 0;
        m_done = 0;
        if (m_seen == 4'hF) begin
            m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_dp = m_dpl;
            m_err = |m_bad;
            m_valid = 1;
            m_done = 1;
            m_seen = 0;
            m_bad = 0;
        end
        if (cap) since = 0;
        else begin
            since++;
            if (since == TIMEOUT) begin
                since = 0;
                m_valid = 0;
                m_seen = 0;
                m_bad = 0;
            end
        end
        if (cap) begin
            nb = 0;
            bd = 1;
            for (int j = 0; j < 16; j++) if (pat[j] == ~d[6:0]) begin nb = 4'(j); bd = 0; end
            m_nib[slot] = nb;
            m_dpl[slot] = ~d[7];
            m_bad[slot] = bd;
            m_seen[slot] = 1;
        end
        hq[0] = hq[1];
        hq[1] = hq[2];
        hq[2] = pin;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge({digit, segments});
        #1;
        if (frame_done === 1'b1) frames++;
        chk("value", value, m_value);
        chk("dp", {12'h0, dp}, {12'h0, m_dp});
        chk("valid", {15'h0, valid}, {15'h0, m_valid});
        chk("frame_done", {15'h0, frame_done}, {15'h0, m_done});
        chk("decode_err", {15'h0, decode_err}, {15'h0, m_err});
    endtask

    task automatic show(input logic [3:0] dg, input logic [7:0] sg, input int n);
        digit = dg;
        segments = sg;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_value", value, 16'h0000);
        chk("reset_valid", {15'h0, valid}, 16'h0);
        chk("reset_done", {15'h0, frame_done}, 16'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'hC0C0F999, 1'b0, 16'h0014, 4'h0, 1'b0};
        vecs[1] = '{32'hF9B6B099, 1'b0, 16'h1034, 4'h0, 1'b1};
        vecs[2] = '{32'hF9A4B099, 1'b1, 16'h1234, 4'h0, 1'b0};
        vecs[3] = '{32'hA1468308, 1'b0, 16'hDCBA, 4'h5, 1'b0};
        vecs[4] = '{32'h10000E06, 1'b0, 16'h98FE, 4'hF, 1'b0};
        reset = 1'b1;
        digit = 4'hF;
        segments = 8'hFF;
        model_reset();
        repeat (2) tick();
        chk("por_value", value, 16'h0000);
        reset = 1'b0;

        foreach (vecs[k]) begin
            frames = 0;
            for (int d = 0; d < 4; d++) begin
                if (vecs[k].junk && d == 2) show(4'b1100, 8'hC0, 10);
                show(sel_of(d), vecs[k].seg[d], 10);
            end
            chk("vec_frames", 16'(frames), 16'd1);
            chk("vec_value", value, vecs[k].exp_value);
            chk("vec_dp", {12'h0, dp}, {12'h0, vecs[k].exp_dp});
            chk("vec_err", {15'h0, decode_err}, {15'h0, vecs[k].exp_err});
            chk("vec_valid", {15'h0, valid}, 16'h1);
        end

        frames = 0;
        show(sel_of(0), 8'h99, 10);
        show(sel_of(1), 8'hF9, 10);
        show(sel_of(2), 8'hC0, 10);
        for (int i = 0; i < 10; i++) show(sel_of(3), (i % 2 == 0) ? 8'hC0 : 8'hF9, 2);
        chk("glitch_frames", 16'(frames), 16'd0);
        show(sel_of(3), 8'hC0, 10);
        chk("glitch_done_frames", 16'(frames), 16'd1);
        chk("glitch_value", value, 16'h0014);

        show(4'hF, 8'hFF, 30);
        chk("timeout_early_valid", {15'h0, valid}, 16'h1);
        show(4'hF, 8'hFF, 40);
        chk("timeout_valid", {15'h0, valid}, 16'h0);
        chk("timeout_value", value, 16'h0014);
        frames = 0;
        for (int d = 0; d < 4; d++) show(sel_of(d), vecs[3].seg[d], 10);
        chk("resume_frames", 16'(frames), 16'd1);
        chk("resume_valid", {15'h0, valid}, 16'h1);
        chk("resume_value", value, 16'hDCBA);

        show(sel_of(0), 8'h99, 10);
        show(sel_of(1), 8'hF9, 10);
        do_reset();
        frames = 0;
        show(sel_of(2), 8'hA4, 10);
        show(sel_of(3), 8'hF9, 10);
        chk("rst_partial_frames", 16'(frames), 16'd0);
        chk("rst_partial_valid", {15'h0, valid}, 16'h0);
        for (int d = 0; d < 4; d++) show(sel_of(d), vecs[2].seg[d], 10);
        chk("rst_full_frames", 16'(frames), 16'd1);
        chk("rst_full_value", value, 16'h1234);

        for (int it = 0; it < 150; it++) begin
            int r;
            logic [3:0] dg;
            logic [7:0] sg;
            r = $urandom_range(0, 9);
            dg = r < 7 ? sel_of($urandom_range(0, 3)) : r == 7 ? 4'hF : 4'($urandom);
            sg = $urandom_range(0, 7) == 0 ? 8'($urandom) : {1'($urandom_range(0, 1)), ~pat[$urandom_range(0, 15)]};
            show(dg, sg, $urandom_range(1, 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive clock edges the synchronised {digit,segments} pair must hold unchanged before capture (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 1024: clock edges without any capture before the display is declared lost (legal range 16..65535).
REQ-003 SHALL have port clock  input  1: single clock, all flops rising-edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port segments  input  8: active-low, [0]=a .. [6]=g, [7]=dp; asynchronous to clock.
REQ-006 SHALL have port digit  input  4: active-low anode select; digit[3]=most significant digit; asynchronous to clock.
REQ-007 SHALL have port value  output  16: last complete frame, hex, digit n in bits [4n+3:4n].
REQ-008 SHALL have port dp  output  4: decimal point per digit of the last frame, 1=lit.
REQ-009 SHALL have port valid  output  1: high while value reflects a live display.
REQ-010 SHALL have port frame_done  output  1: one-cycle pulse on each frame publish.
REQ-011 SHALL have port decode_err  output  1: last published frame had at least one unrecognised segment pattern.

Function
REQ-012 SHALL pass {digit,segments} through a 2-flop synchroniser (s1,s2) plus a third register s3 for change detection.
REQ-013 SHALL clear the stability counter when s2!=s3 and otherwise increment it, saturating at SETTLE.
REQ-014 SHALL use a 2-state capture FSM: SETTLING (counter running) -> HELD on the edge the counter reaches SETTLE; HELD -> SETTLING on any s2!=s3; HELD never captures twice.
REQ-015 SHALL capture only on the SETTLING->HELD edge and only if s2 digit field has exactly one bit low; all-high (blank) or multi-low selects enter HELD without capture.
REQ-016 SHALL decode inverted segments[6:0] (gfedcba, 1=lit): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F.
REQ-017 SHALL store any other pattern as nibble 0 and set that slot's bad flag.
REQ-018 SHALL store nibble, dp (=~segments[7]) and bad flag into the slot indexed by the selected digit and set that slot's seen bit; recapturing an already-seen slot overwrites it.
REQ-019 SHALL publish on the edge after the capture that makes the seen mask 4'b1111: value, dp, decode_err (=OR of bad flags) update atomically, frame_done=1 for exactly that cycle, valid=1, seen mask and bad flags cleared.
REQ-020 SHALL keep value/dp/decode_err unchanged between publishes.
REQ-021 SHALL count edges since the last capture; on reaching TIMEOUT: valid=0, seen mask and bad flags cleared, value/dp retained; the next publish sets valid=1 again.
REQ-022 SHALL give a capture precedence over timeout expiry on the same edge (counter reloads, no timeout).
REQ-023 SHALL produce a pin-to-capture latency of 2 (sync) + 1 (s3) + SETTLE edges for a stable input, publish one edge later.

Reset
REQ-024 SHALL on reset asynchronously set: value=16'h0000, dp=4'h0, valid=0, frame_done=0, decode_err=0, FSM=SETTLING, counters=0, seen mask=0, bad flags=0, synchroniser/s3 = all ones (blank).
REQ-025 SHALL on reset mid-frame discard partial slots; the first publish after release requires all four digits recaptured.

Verification
REQ-026 Scan digits 0..3 active-low (1110,1101,1011,0111) with segments for 4,1,0,0 (~66,~06,~3F,~3F), 10 edges each -> value=16'h0014, dp=0, one frame_done pulse per 4-digit scan, valid=1, decode_err=0.
REQ-027 Glitch: segments toggle every 2 edges for 20 edges on one digit, SETTLE=4 -> no capture, seen mask unchanged, no frame_done.
REQ-028 Digit 2 shows 8'hFF^8'h49 (unknown pattern) in otherwise valid scan of 1,2,3,4 -> value=16'h1034... with digit 2 nibble 0, decode_err=1; next clean scan clears decode_err.
REQ-029 Stop scanning (digit=4'hF) for TIMEOUT=64 edges after a publish -> valid falls on edge 64, value retained; resume scan -> valid=1 at next publish.
REQ-030 Assert reset after digits 0,1 captured, release, scan 2,3 only -> no frame_done; full scan then -> one frame_done with new value.
REQ-031 Drive digit=4'b1100 stable 10 edges between valid digits -> ignored, no slot written, frame completes normally.
